// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sender: FSM encoding and LFSR constants.
package traffic_pkg;

  localparam int LFSR_W = 16;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Mirror a 16-bit word end for end; gives the data LFSR a seed distinct from the gap LFSR.
  function automatic logic [LFSR_W-1:0] bit_rev16(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] r;
    for (int i = 0; i < LFSR_W; i++) begin
      r[i] = v[LFSR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/traffic_sender_if.sv
// Payload stream interface between the traffic sender and its receiver.
//
// Handshake: a beat transfers on a rising clk edge where valid=1 and ready=1.
// Once valid is raised, valid and data hold stable until that transfer
// completes; ready may toggle freely and has no combinational path to valid.
interface traffic_sender_if #(
  parameter int DATA_W = 4
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances one step only when step=1; exposes its low OUT_W bits.
module lfsr16
  import traffic_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [OUT_W-1:0] low
);

  // An all-zero state would lock up, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] state;

  // Reseed on reset, otherwise shift right and fold in the taps when bit 0 leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED_NZ;
    end else if (step) begin
      state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_POLY : '0);
    end
  end

  assign low = state[OUT_W-1:0];

endmodule

// File: rtl/traffic_sender.sv
// Traffic generator: offers payloads on a valid/ready stream with programmable
// (fixed or pseudo-random) idle gaps between transfers.
module traffic_sender
  import traffic_pkg::*;
#(
  parameter int          DATA_W = 4,
  parameter int          GAP_W  = 8,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [GAP_W-1:0]     gap_from,
  input  logic [GAP_W-1:0]     gap_to,
  traffic_sender_if.master     bus,
  output logic [CNT_W-1:0]     sent,
  output logic                 busy,
  output state_t               state
);

  localparam logic [LFSR_W-1:0] DATA_SEED = bit_rev16(SEED);
  localparam logic [GAP_W:0]    ONE_G     = 1;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_len;
  logic [GAP_W-1:0]   gap_rand;
  logic [GAP_W:0]     span;
  logic [GAP_W:0]     rem;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  inc_q;
  logic [DATA_W-1:0]  data_rand;
  logic [CNT_W-1:0]   sent_q;
  logic               xfer;

  assign xfer = (state_q == SEND) && bus.ready;

  lfsr16 #(.SEED(SEED), .OUT_W(GAP_W)) u_gap_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (xfer),
    .low  (gap_rand)
  );

  lfsr16 #(.SEED(DATA_SEED), .OUT_W(DATA_W)) u_data_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (xfer),
    .low  (data_rand)
  );

  // Gap length for the current cycle: fixed gap_from, or gap_from plus a random offset
  // within [0, gap_to-gap_from]; span is one bit wider so a full-range window cannot overflow.
  always_comb begin
    span    = {1'b0, gap_to} - {1'b0, gap_from} + ONE_G;
    rem     = '0;
    gap_len = gap_from;
    if (gap_to > gap_from) begin
      rem     = {1'b0, gap_rand} % span;
      gap_len = gap_from + GAP_W'(rem);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SEND is only left on a completed transfer so valid never drops early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (!enable) state_d = IDLE;
          else if (gap_len != '0) state_d = GAP;
        end
      end
      GAP: begin
        if (!enable) state_d = IDLE;
        else if (gap_cnt <= GAP_W'(1)) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    bus.valid = (state_q == SEND);
    busy      = (state_q != IDLE);
    state     = state_q;
  end

  // Datapath: payload and transfer count move only on a transfer; the gap counter
  // is loaded with the gap length and counts the idle cycles down.
  // The incrementing value only advances when it is the payload chosen, so a
  // stretch of random payloads resumes the count where it left off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
      data_q  <= '0;
      inc_q   <= '0;
      sent_q  <= '0;
    end else begin
      if (xfer) begin
        sent_q <= sent_q + CNT_W'(1);
        if (mode) begin
          data_q <= data_rand;
        end else begin
          data_q <= inc_q + DATA_W'(1);
          inc_q  <= inc_q + DATA_W'(1);
        end
      end
      if (xfer && enable) begin
        gap_cnt <= gap_len;
      end else if (state_q == GAP) begin
        gap_cnt <= (enable && gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
      end
    end
  end

  assign bus.data = data_q;
  assign sent     = sent_q;

endmodule
